qam16_symbol_packer: RTL and testbench

- Receive-side counterpart of the QAM16 data generator.
- Accepts demodulated 4-bit QAM16 symbols on an AXI-Stream slave and packs 8 consecutive symbols into one 32-bit word.
- Presents each word on an AXI-Stream master for the downstream data sink or checker.
- Supports frame realignment through a start-of-frame flag, and counts completed words and discarded partial words.

---
 rtl/qam16_symbol_packer.sv | 106 ++++++++++
 tb/tb_qam16_symbol_packer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_symbol_packer.sv
// qam16_symbol_packer
// Receive-side packer: collects eight demodulated 4-bit QAM16 symbols from an
// AXI-Stream slave and presents them as one 32-bit word on an AXI-Stream master.
// A start-of-frame flag (s_axis_tuser) realigns the word boundary and discards
// any partial word collected so far. Completed and discarded words are counted.

module qam16_symbol_packer #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 resetn,
    input  logic [3:0]           s_axis_tdata,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 drop_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0] sr;
    logic [2:0]  idx;
    logic        s_acc;
    logic        m_acc;
    logic        last_sym;
    logic [31:0] sr_shifted;
    logic [31:0] sr_restart;

    // Symbols 0..6 may be collected while a finished word still waits downstream;
    // only the word-completing symbol is held off until the output register frees up.
    always_comb begin
        last_sym      = (idx == 3'd7);
        s_axis_tready = !(last_sym && m_axis_tvalid && !m_axis_tready);
        s_acc         = s_axis_tvalid && s_axis_tready;
        m_acc         = m_axis_tvalid && m_axis_tready;
    end

    // Shift direction decides where the first symbol of a word ends up; a restart
    // seeds the register so that the new symbol finishes in the symbol-0 slot.
    always_comb begin
        sr_shifted = 32'd0;
        sr_restart = 32'd0;
        if (MSB_FIRST) begin
            sr_shifted = {sr[27:0], s_axis_tdata};
            sr_restart = {28'd0, s_axis_tdata};
        end else begin
            sr_shifted = {s_axis_tdata, sr[31:4]};
            sr_restart = {s_axis_tdata, 28'd0};
        end
    end

    // Symbol collection and output register; a completion in the same cycle as a
    // downstream accept overrides the clear of tvalid so no bubble is inserted.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            sr            <= 32'd0;
            idx           <= 3'd0;
            m_axis_tdata  <= 32'd0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (m_acc) begin
                m_axis_tvalid <= 1'b0;
            end
            if (s_acc) begin
                if (s_axis_tuser) begin
                    sr  <= sr_restart;
                    idx <= 3'd1;
                end else begin
                    sr <= sr_shifted;
                    if (last_sym) begin
                        m_axis_tdata  <= sr_shifted;
                        m_axis_tvalid <= 1'b1;
                        idx           <= 3'd0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
            end
        end
    end

    // Statistics: accepted words, discarded partial words and a one-cycle drop strobe.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            word_count <= '0;
            drop_count <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (m_acc) begin
                word_count <= word_count + CNT_ONE;
            end
            if (s_acc && s_axis_tuser && (idx != 3'd0)) begin
                drop_count <= drop_count + CNT_ONE;
                drop_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qam16_symbol_packer.sv
// tb_qam16_symbol_packer
// Drives two packers (MSB-first and LSB-first) with identical stimulus and
// compares them every cycle against a queue-based reference model.

module tb_qam16_symbol_packer;

    logic        aclk;
    logic        resetn;
    logic [3:0]  sTdata;
    logic        sTuser;
    logic        sTvalid;
    logic        mTready;

    logic        sTreadyMsb, sTreadyLsb;
    logic [31:0] mTdataMsb, mTdataLsb;
    logic        mTvalidMsb, mTvalidLsb;
    logic [31:0] wordCountMsb, wordCountLsb;
    logic [31:0] dropCountMsb, dropCountLsb;
    logic        dropPulseMsb, dropPulseLsb;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    bit [3:0]    curSyms[$];
    bit [31:0]   outMsb[$];
    bit [31:0]   outLsb[$];
    int unsigned expWordCount = 0;
    int unsigned expDropCount = 0;
    bit          expDropPulse = 1'b0;
    bit          togglePhase  = 1'b0;

    qam16_symbol_packer #(.MSB_FIRST(1'b1), .CNT_WIDTH(32)) dutMsb (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tdata(sTdata), .s_axis_tuser(sTuser), .s_axis_tvalid(sTvalid),
        .s_axis_tready(sTreadyMsb),
        .m_axis_tdata(mTdataMsb), .m_axis_tvalid(mTvalidMsb), .m_axis_tready(mTready),
        .word_count(wordCountMsb), .drop_count(dropCountMsb), .drop_pulse(dropPulseMsb)
    );

    qam16_symbol_packer #(.MSB_FIRST(1'b0), .CNT_WIDTH(32)) dutLsb (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tdata(sTdata), .s_axis_tuser(sTuser), .s_axis_tvalid(sTvalid),
        .s_axis_tready(sTreadyLsb),
        .m_axis_tdata(mTdataLsb), .m_axis_tvalid(mTvalidLsb), .m_axis_tready(mTready),
        .word_count(wordCountLsb), .drop_count(dropCountLsb), .drop_pulse(dropPulseLsb)
    );

    // Free-running clock, 10 time units per period
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Watchdog so a stuck run still terminates with a report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Pack the eight collected symbols; symbol i is the i-th received
    function automatic bit [31:0] packWord(input bit msbFirst);
        bit [31:0] word = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (msbFirst) word = word + (32'(curSyms[i]) << (4 * (7 - i)));
            else          word = word + (32'(curSyms[i]) << (4 * i));
        end
        return word;
    endfunction

    task automatic modelReset();
        curSyms.delete();
        outMsb.delete();
        outLsb.delete();
        expWordCount = 0;
        expDropCount = 0;
        expDropPulse = 1'b0;
    endtask

    // One clock cycle: drive inputs, check both DUTs against the model, advance the model
    task automatic applyStimulus(input logic [3:0] sym, input logic user, input logic valid,
                                 input logic mready, output bit accepted);
        bit expReady;
        bit mAcc;
        sTdata  = sym;
        sTuser  = user;
        sTvalid = valid;
        mTready = mready;
        #1;
        expReady = !(curSyms.size() == 7 && outMsb.size() != 0 && !mready);
        checkOutput("tready msb", sTreadyMsb, expReady);
        checkOutput("tready lsb", sTreadyLsb, expReady);
        checkOutput("tvalid msb", mTvalidMsb, outMsb.size() != 0);
        checkOutput("tvalid lsb", mTvalidLsb, outLsb.size() != 0);
        if (outMsb.size() != 0) begin
            checkOutput("tdata msb", mTdataMsb, outMsb[0]);
            checkOutput("tdata lsb", mTdataLsb, outLsb[0]);
        end
        checkOutput("word_count msb", wordCountMsb, expWordCount);
        checkOutput("word_count lsb", wordCountLsb, expWordCount);
        checkOutput("drop_count msb", dropCountMsb, expDropCount);
        checkOutput("drop_count lsb", dropCountLsb, expDropCount);
        checkOutput("drop_pulse msb", dropPulseMsb, expDropPulse);
        checkOutput("drop_pulse lsb", dropPulseLsb, expDropPulse);

        accepted     = valid && expReady;
        mAcc         = (outMsb.size() != 0) && mready;
        expDropPulse = 1'b0;
        if (mAcc) begin
            void'(outMsb.pop_front());
            void'(outLsb.pop_front());
            expWordCount++;
        end
        if (accepted) begin
            if (user) begin
                if (curSyms.size() != 0) begin
                    expDropCount++;
                    expDropPulse = 1'b1;
                end
                curSyms.delete();
            end
            curSyms.push_back(sym);
            if (curSyms.size() == 8) begin
                outMsb.push_back(packWord(1'b1));
                outLsb.push_back(packWord(1'b0));
                curSyms.delete();
            end
        end
        @(negedge aclk);
    endtask

    // mode 0: tready low, 1: tready high, 2: tready toggling, 3: random valid and tready
    task automatic sendSymbol(input logic [3:0] sym, input logic user, input int mode);
        bit   acc = 1'b0;
        int   tries = 0;
        logic v;
        logic mr;
        while (!acc && tries < 40) begin
            togglePhase = ~togglePhase;
            case (mode)
                0:       mr = 1'b0;
                1:       mr = 1'b1;
                2:       mr = togglePhase;
                default: mr = 1'($urandom);
            endcase
            v = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (v) applyStimulus(sym, user, 1'b1, mr, acc);
            else   applyStimulus(4'($urandom), 1'($urandom), 1'b0, mr, acc);
            tries++;
        end
        if (!acc) checkOutput("send timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit acc;
        int tries = 0;
        while (outMsb.size() != 0 && tries < 20) begin
            applyStimulus(4'($urandom), 1'($urandom), 1'b0, 1'b1, acc);
            tries++;
        end
        if (outMsb.size() != 0) checkOutput("drain timeout", 64'd0, 64'd1);
    endtask

    // Asynchronous assert checked 1 time unit later, release on a later negedge
    task automatic doReset();
        resetn  = 1'b0;
        sTvalid = 1'b0;
        #1;
        checkOutput("reset tdata msb", mTdataMsb, 0);
        checkOutput("reset tdata lsb", mTdataLsb, 0);
        checkOutput("reset tvalid msb", mTvalidMsb, 0);
        checkOutput("reset tvalid lsb", mTvalidLsb, 0);
        checkOutput("reset word_count", wordCountMsb, 0);
        checkOutput("reset drop_count", dropCountLsb, 0);
        checkOutput("reset drop_pulse", dropPulseMsb, 0);
        checkOutput("reset tready", sTreadyMsb, 1);
        modelReset();
        @(negedge aclk);
        resetn = 1'b1;
    endtask

    initial begin
        bit acc;
        resetn  = 1'b0;
        sTdata  = 4'd0;
        sTuser  = 1'b0;
        sTvalid = 1'b0;
        mTready = 1'b1;
        @(negedge aclk);
        doReset();

        // Basic packing, both orders
        for (int i = 1; i <= 8; i++) sendSymbol(4'(i), 1'b0, 1);
        checkOutput("basic tvalid", mTvalidMsb, 1);
        checkOutput("basic word msb", mTdataMsb, 32'h12345678);
        checkOutput("basic word lsb", mTdataLsb, 32'h87654321);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, acc);
        checkOutput("basic single cycle", mTvalidMsb, 0);
        checkOutput("basic word_count", wordCountMsb, 1);

        // Backpressure: second word completes only once the first is taken
        doReset();
        for (int i = 0; i < 15; i++) sendSymbol(4'hA, 1'b0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(4'hA, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("stall tready", sTreadyMsb, 0);
        checkOutput("stall hold", mTdataMsb, 32'hAAAAAAAA);
        sendSymbol(4'hA, 1'b0, 1);
        drain();
        checkOutput("stall word_count", wordCountLsb, 2);

        // Realignment drops a partial word
        doReset();
        for (int i = 0; i < 3; i++) sendSymbol(4'($urandom), 1'b0, 1);
        sendSymbol(4'hF, 1'b1, 1);
        for (int i = 0; i < 7; i++) sendSymbol(4'h0, 1'b0, 1);
        checkOutput("realign word msb", mTdataMsb, 32'hF0000000);
        checkOutput("realign word lsb", mTdataLsb, 32'h0000000F);
        checkOutput("realign drop_count", dropCountMsb, 1);
        drain();

        // Toggling downstream ready
        doReset();
        for (int i = 0; i < 64; i++) sendSymbol(4'($urandom), 1'b0, 2);
        drain();
        checkOutput("toggle word_count", wordCountMsb, 8);

        // Reset in the middle of a word
        doReset();
        for (int i = 0; i < 5; i++) sendSymbol(4'($urandom), 1'b0, 1);
        doReset();
        for (int i = 8; i >= 1; i--) sendSymbol(4'(i), 1'b0, 1);
        checkOutput("post reset word msb", mTdataMsb, 32'h87654321);
        checkOutput("post reset word lsb", mTdataLsb, 32'h12345678);
        drain();
        checkOutput("post reset word_count", wordCountMsb, 1);
        checkOutput("post reset drop_count", dropCountMsb, 0);

        // Randomized traffic with occasional start-of-frame
        doReset();
        for (int i = 0; i < 400; i++)
            sendSymbol(4'($urandom), 1'($urandom_range(0, 11) == 0), 3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
